// File: rtl/obi_sram_slave_pipe.sv
// OBI subordinate in front of a byte-addressable single-port SRAM model.
// Accesses complete on the accept edge; responses queue in an in-order FIFO.
module obi_sram_slave_pipe #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MEM_DEPTH       = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned OFF_LSB = $clog2(BE_W);
  localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(MEM_DEPTH * BE_W);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [DATA_WIDTH-1:0] mem       [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [MAX_OUTSTANDING];
  logic                  fifo_err  [MAX_OUTSTANDING];

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  reset_q;

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Range test is done in full address width so wrap-around below BASE_ADDR is caught.
  assign off      = obi_addr_i - BASE_ADDR;
  assign idx      = off[OFF_LSB +: IDX_W];
  assign in_range = (obi_addr_i >= BASE_ADDR) && (off < SPAN);

  // Grant only from registered state; a pop this cycle frees a slot for the next one.
  assign obi_gnt_o    = !reset_q && (count < CNT_MAX);
  assign push         = obi_req_i && obi_gnt_o && !reset_i;
  assign pop          = obi_rvalid_o && obi_rready_i && !reset_i;

  assign obi_rvalid_o = (count != '0);
  assign obi_rdata_o  = obi_rvalid_o ? fifo_data[rd_ptr] : '0;
  assign obi_err_o    = obi_rvalid_o && fifo_err[rd_ptr];

  assign resp_data    = (!obi_we_i && in_range) ? mem[idx] : '0;
  assign resp_err     = !in_range;

  always_ff @(posedge clk_i) begin
    if (push && obi_we_i && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (obi_be_i[i]) mem[idx][8*i +: 8] <= obi_wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= resp_data;
      fifo_err[wr_ptr]  <= resp_err;
    end
  end

  always_ff @(posedge clk_i) begin
    reset_q <= reset_i;
    if (reset_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_obi_sram_slave_pipe.sv
// Directed bench for obi_sram_slave_pipe (32-bit data, 64 words at 0x1000, 2 outstanding).
module tb_obi_sram_slave_pipe;

  localparam int MAXO = 2;

  logic        clk     = 1'b0;
  logic        reset_i = 1'b1;
  logic        req     = 1'b0;
  logic        we      = 1'b0;
  logic        rready  = 1'b0;
  logic [31:0] addr    = '0;
  logic [31:0] wdata   = '0;
  logic [3:0]  be      = '0;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  int total  = 0;
  int passed = 0;

  logic [31:0] t3_exp [4];

  obi_sram_slave_pipe #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64),
    .BASE_ADDR(32'h0000_1000), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
    .obi_be_i(be), .obi_wdata_i(wdata),
    .obi_rvalid_o(rvalid), .obi_rready_i(rready),
    .obi_rdata_o(rdata), .obi_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int i = 0; i < 20 && !gnt; i++) step();
    chk("grant_wait", gnt, 1);
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] d, input logic e);
    for (int i = 0; i < 20 && !rvalid; i++) step();
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_err"}, err, e);
    step();
  endtask

  // Outstanding-count model: rvalid must track it and no push may land on a full FIFO.
  int   cnt   = 0;
  logic armed = 1'b0;
  always @(negedge clk) begin
    if (armed) begin
      total++;
      assert (rvalid === (cnt != 0)) passed++;
      else $error("FAIL mon_rvalid: observed %b expected %b", rvalid, cnt != 0);
      if (!reset_i && req && gnt) begin
        total++;
        assert (cnt < MAXO) passed++;
        else $error("FAIL mon_push_full: outstanding %0d required below %0d", cnt, MAXO);
      end
    end
    if (reset_i) begin
      cnt   = 0;
      armed = 1'b1;
    end else begin
      cnt = cnt + int'(req && gnt) - int'(rvalid && rready);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // T1: reset held with a pending request
    req = 1'b1; we = 1'b0; addr = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_gnt", gnt, 0);
      chk("t1_rvalid", rvalid, 0);
      chk("t1_rdata", rdata, 0);
      chk("t1_err", err, 0);
    end
    reset_i = 1'b0; req = 1'b0;
    chk("t1_gnt_release_cycle", gnt, 0);
    step();
    chk("t1_gnt_after", gnt, 1);
    rready = 1'b1;

    // T2: partial write then read back, plus table setup
    access(1, 32'h1008, 4'b1111, 32'h1122_3344); expect_resp("t2_w1", 0, 0);
    access(1, 32'h1008, 4'b0101, 32'hAABB_CCDD); expect_resp("t2_w2", 0, 0);
    access(0, 32'h1008, 4'b1111, 32'h0);         expect_resp("t2_rd", 32'h11BB_33DD, 0);
    access(1, 32'h1000, 4'b1111, 32'h0000_0010); expect_resp("init0", 0, 0);
    access(1, 32'h1004, 4'b1111, 32'h0404_0404); expect_resp("init1", 0, 0);
    access(1, 32'h100C, 4'b1111, 32'h0C0C_0C0C); expect_resp("init3", 0, 0);
    access(1, 32'h10FC, 4'b1111, 32'hCAFE_F00D); expect_resp("init_top", 0, 0);
    access(1, 32'h1000, 4'b0000, 32'hFFFF_FFFF); expect_resp("be0_w", 0, 0);
    access(0, 32'h1001, 4'b0000, 32'h0);         expect_resp("be0_rd", 32'h0000_0010, 0);

    // T3: four back-to-back reads with rready held high
    t3_exp[0] = 32'h0000_0010; t3_exp[1] = 32'h0404_0404;
    t3_exp[2] = 32'h11BB_33DD; t3_exp[3] = 32'h0C0C_0C0C;
    req = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h1000 + 32'(4 * i);
      chk("t3_gnt", gnt, 1);
      if (i > 0) begin
        chk("t3_rvalid", rvalid, 1);
        chk("t3_rdata", rdata, t3_exp[i-1]);
      end
      step();
    end
    req = 1'b0;
    chk("t3_rvalid_last", rvalid, 1);
    chk("t3_rdata_last", rdata, t3_exp[3]);
    step();
    chk("t3_drained", rvalid, 0);

    // T4: backpressure fills the FIFO and stalls the third read
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h1000;
    chk("t4_gnt_a", gnt, 1);
    step();
    addr = 32'h1004;
    chk("t4_gnt_b", gnt, 1);
    step();
    addr = 32'h1008;
    chk("t4_gnt_full", gnt, 0);
    chk("t4_head", rdata, 32'h0000_0010);
    step();
    chk("t4_gnt_still_full", gnt, 0);
    chk("t4_head_stable", rdata, 32'h0000_0010);
    rready = 1'b1;
    step();
    chk("t4_gnt_after_pop", gnt, 1);
    chk("t4_second", rdata, 32'h0404_0404);
    step();
    req = 1'b0;
    chk("t4_third", rdata, 32'h11BB_33DD);
    step();
    chk("t4_drained", rvalid, 0);

    // T5: out-of-range accesses around a base of 0x1000
    access(1, 32'h1100, 4'b1111, 32'hDEAD_BEEF); expect_resp("t5_wr_oob", 0, 1);
    access(0, 32'h10FC, 4'b1111, 32'h0);         expect_resp("t5_rd_top", 32'hCAFE_F00D, 0);
    access(0, 32'h0FFC, 4'b1111, 32'h0);         expect_resp("t5_rd_below", 0, 1);
    access(0, 32'h1100, 4'b1111, 32'h0);         expect_resp("t5_rd_above", 0, 1);
    access(0, 32'h1000, 4'b1111, 32'h0);         expect_resp("t5_rd_word0", 32'h0000_0010, 0);

    // T6: reset with two responses pending
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h1000;
    step();
    addr = 32'h1004;
    step();
    req = 1'b0;
    chk("t6_pending", rvalid, 1);
    chk("t6_pending_head", rdata, 32'h0000_0010);
    reset_i = 1'b1;
    step();
    chk("t6_rvalid_reset", rvalid, 0);
    chk("t6_gnt_reset", gnt, 0);
    chk("t6_rdata_reset", rdata, 0);
    chk("t6_err_reset", err, 0);
    reset_i = 1'b0; rready = 1'b1;
    step();
    chk("t6_gnt_after", gnt, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_stale", rvalid, 0);
      step();
    end

    // Write presented on a reset edge must not reach the SRAM
    rready = 1'b0;
    access(0, 32'h1008, 4'b1111, 32'h0);
    chk("rst_wr_gnt", gnt, 1);
    reset_i = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h1004; be = 4'b1111; wdata = 32'hFFFF_FFFF;
    step();
    reset_i = 1'b0; req = 1'b0; we = 1'b0;
    chk("rst_wr_flushed", rvalid, 0);
    step();
    rready = 1'b1;
    access(0, 32'h1004, 4'b1111, 32'h0); expect_resp("rst_wr_rd", 32'h0404_0404, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
